// File: rtl/io_bridge_pkg.sv
// Shared defaults for the processor I/O bridge: data width, FIFO depth and
// the pointer width that follows from the depth.
package io_bridge_pkg;

  localparam int IO_WIDTH = 16;
  localparam int IO_DEPTH = 4;

  function automatic int ptr_bits(input int depth);
    return $clog2(depth);
  endfunction

  localparam int IO_PTR_W = ptr_bits(IO_DEPTH);

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with a masked head output: the head reads as zero when
// the FIFO is empty, so consumers never see stale storage.
module io_fifo
  import io_bridge_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH == IO_DEPTH) ? IO_PTR_W : ptr_bits(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push_acc;
  logic             pop_acc;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the empty mask hides anything left behind.
  always_ff @(posedge clk) begin
    if (reset && push_acc) mem[wr_ptr] <= din;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_bridge.sv
// Bridges the processor's word-wide I/O port to valid/ready streams, with a
// FIFO in each direction and sticky overflow/underflow flags.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cpu_out,
  input  logic             cpu_out_we,
  output logic [WIDTH-1:0] cpu_in,
  input  logic             cpu_in_re,
  output logic             cpu_in_avail,
  output logic             cpu_out_full,
  output logic [WIDTH-1:0] ext_out_data,
  output logic             ext_out_valid,
  input  logic             ext_out_ready,
  input  logic [WIDTH-1:0] ext_in_data,
  input  logic             ext_in_valid,
  output logic             ext_in_ready,
  output logic             ovf,
  output logic             udf
);

  logic out_full;
  logic out_empty;
  logic out_pop;
  logic in_full;
  logic in_empty;
  logic in_push;

  assign out_pop = ext_out_valid && ext_out_ready;

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cpu_out_we),
    .pop   (out_pop),
    .din   (cpu_out),
    .full  (out_full),
    .empty (out_empty),
    .head  (ext_out_data)
  );

  assign ext_out_valid = !out_empty;
  assign cpu_out_full  = out_full;

  // Inbound acceptance is gated on ready alone so the producer never sees a
  // handshake that depends on what the processor does this cycle.
  assign ext_in_ready = !in_full;
  assign in_push      = ext_in_valid && ext_in_ready;

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_push),
    .pop   (cpu_in_re),
    .din   (ext_in_data),
    .full  (in_full),
    .empty (in_empty),
    .head  (cpu_in)
  );

  assign cpu_in_avail = !in_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (cpu_out_we && out_full && !out_pop) ovf <= 1'b1;
      if (cpu_in_re && in_empty)              udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: outbound latency, overflow, full-with-pop,
// inbound ordering, underflow, inbound backpressure and mid-traffic reset.
module tb_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_out;
  logic        cpu_out_we;
  logic [15:0] cpu_in;
  logic        cpu_in_re;
  logic        cpu_in_avail;
  logic        cpu_out_full;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic [15:0] ext_in_data;
  logic        ext_in_valid;
  logic        ext_in_ready;
  logic        ovf;
  logic        udf;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  io_bridge #(.WIDTH(16), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_out       (cpu_out),
    .cpu_out_we    (cpu_out_we),
    .cpu_in        (cpu_in),
    .cpu_in_re     (cpu_in_re),
    .cpu_in_avail  (cpu_in_avail),
    .cpu_out_full  (cpu_out_full),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .ovf           (ovf),
    .udf           (udf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " ext_out_valid"}, ext_out_valid, 0);
    checkOutput({tag, " ext_out_data"},  ext_out_data,  0);
    checkOutput({tag, " cpu_in"},        cpu_in,        0);
    checkOutput({tag, " cpu_in_avail"},  cpu_in_avail,  0);
    checkOutput({tag, " cpu_out_full"},  cpu_out_full,  0);
    checkOutput({tag, " ext_in_ready"},  ext_in_ready,  1);
    checkOutput({tag, " ovf"},           ovf,           0);
    checkOutput({tag, " udf"},           udf,           0);
  endtask

  initial begin
    reset = 1'b0; cpu_out = '0; cpu_out_we = 1'b0; cpu_in_re = 1'b0;
    ext_out_ready = 1'b0; ext_in_data = '0; ext_in_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    checkIdle("reset");
    reset = 1'b1;
    applyStimulus();

    // Single word passes straight through with one-cycle latency
    cpu_out = 16'hA5A5; cpu_out_we = 1'b1; ext_out_ready = 1'b1;
    applyStimulus();
    cpu_out_we = 1'b0;
    checkOutput("single valid", ext_out_valid, 1);
    checkOutput("single data",  ext_out_data,  16'hA5A5);
    applyStimulus();
    checkOutput("single gone valid", ext_out_valid, 0);
    checkOutput("single gone data",  ext_out_data,  0);

    // Fill to full, drop the fifth word, drain in order
    ext_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cpu_out = 16'(i); cpu_out_we = 1'b1;
      applyStimulus();
      if (i == 3) checkOutput("full after 3", cpu_out_full, 0);
      if (i == 4) begin
        checkOutput("full after 4", cpu_out_full, 1);
        checkOutput("ovf after 4",  ovf, 0);
      end
    end
    cpu_out_we = 1'b0;
    checkOutput("ovf after 5", ovf, 1);
    ext_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain valid", ext_out_valid, 1);
      checkOutput("drain data",  ext_out_data,  16'(i));
      applyStimulus();
    end
    checkOutput("drained valid", ext_out_valid, 0);
    checkOutput("ovf sticky",    ovf, 1);

    reset = 1'b0;
    applyStimulus();
    reset = 1'b1;
    checkOutput("ovf cleared", ovf, 0);

    // Full FIFO with simultaneous push and pop keeps count and order
    ext_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_out = 16'h0010 + 16'(i); cpu_out_we = 1'b1;
      applyStimulus();
    end
    cpu_out = 16'h0014; cpu_out_we = 1'b1; ext_out_ready = 1'b1;
    applyStimulus();
    cpu_out_we = 1'b0;
    checkOutput("pushpop ovf",  ovf, 0);
    checkOutput("pushpop full", cpu_out_full, 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("pushpop data", ext_out_data, 16'h0010 + 16'(i));
      applyStimulus();
    end
    checkOutput("pushpop empty", ext_out_valid, 0);
    ext_out_ready = 1'b0;

    // Inbound ordering and pop-to-zero
    checkOutput("in ready idle", ext_in_ready, 1);
    ext_in_valid = 1'b1; ext_in_data = 16'h1111;
    applyStimulus();
    ext_in_data = 16'h2222;
    applyStimulus();
    ext_in_valid = 1'b0;
    checkOutput("in head 1",  cpu_in, 16'h1111);
    checkOutput("in avail 1", cpu_in_avail, 1);
    cpu_in_re = 1'b1;
    applyStimulus();
    cpu_in_re = 1'b0;
    checkOutput("in head 2", cpu_in, 16'h2222);
    cpu_in_re = 1'b1;
    applyStimulus();
    cpu_in_re = 1'b0;
    checkOutput("in head empty", cpu_in, 0);
    checkOutput("in avail 0",    cpu_in_avail, 0);
    checkOutput("udf clean",     udf, 0);

    // Read from empty sets udf
    cpu_in_re = 1'b1;
    applyStimulus();
    cpu_in_re = 1'b0;
    checkOutput("udf set",     udf, 1);
    checkOutput("udf cpu_in",  cpu_in, 0);
    checkOutput("udf avail",   cpu_in_avail, 0);

    // Inbound backpressure: a full FIFO refuses input even while being read
    ext_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ext_in_data = 16'hC000 + 16'(i);
      applyStimulus();
    end
    checkOutput("in full ready", ext_in_ready, 0);
    checkOutput("in full head",  cpu_in, 16'hC001);
    ext_in_data = 16'hDEAD; cpu_in_re = 1'b1;
    checkOutput("in ready ignores re", ext_in_ready, 0);
    applyStimulus();
    ext_in_valid = 1'b0; cpu_in_re = 1'b0;
    checkOutput("in after pop head",  cpu_in, 16'hC002);
    checkOutput("in after pop ready", ext_in_ready, 1);

    // Partially filled FIFOs, reset while traffic is offered
    cpu_out = 16'hB001; cpu_out_we = 1'b1;
    applyStimulus();
    cpu_out = 16'hB002;
    applyStimulus();
    cpu_out_we = 1'b0;
    checkOutput("pre-reset out data", ext_out_data, 16'hB001);
    reset = 1'b0; cpu_out = 16'hB003; cpu_out_we = 1'b1; ext_out_ready = 1'b1;
    ext_in_valid = 1'b1; ext_in_data = 16'hE0E0; cpu_in_re = 1'b1;
    applyStimulus();
    reset = 1'b1; cpu_out_we = 1'b0; ext_out_ready = 1'b0;
    ext_in_valid = 1'b0; cpu_in_re = 1'b0;
    checkIdle("mid reset");
    applyStimulus();
    checkIdle("post reset");

    cpu_out = 16'hB004; cpu_out_we = 1'b1;
    ext_in_valid = 1'b1; ext_in_data = 16'hE001;
    applyStimulus();
    cpu_out_we = 1'b0; ext_in_valid = 1'b0;
    checkOutput("fresh out data", ext_out_data, 16'hB004);
    checkOutput("fresh in data",  cpu_in, 16'hE001);
    cpu_in_re = 1'b1; ext_out_ready = 1'b1;
    applyStimulus();
    cpu_in_re = 1'b0; ext_out_ready = 1'b0;
    checkOutput("fresh out empty", ext_out_valid, 0);
    checkOutput("fresh in empty",  cpu_in, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter: WIDTH, 16, data width of both directions.
REQ-002 Parameter: DEPTH, 4, entries per FIFO; power of two, minimum 2.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 cpu_out  input  WIDTH  processor output data, wired from datapath ioOut.
REQ-006 cpu_out_we  input  1  processor output-write strobe, one cycle per word.
REQ-007 cpu_in  output  WIDTH  processor input data, wired to datapath ioIn.
REQ-008 cpu_in_re  input  1  processor input-read strobe; consumes the current cpu_in word.
REQ-009 cpu_in_avail  output  1  inbound FIFO non-empty.
REQ-010 cpu_out_full  output  1  outbound FIFO full.
REQ-011 ext_out_data  output  WIDTH  outbound word to the external consumer.
REQ-012 ext_out_valid  output  1  ext_out_data is valid.
REQ-013 ext_out_ready  input  1  external consumer accepts the word this cycle.
REQ-014 ext_in_data  input  WIDTH  inbound word from the external producer.
REQ-015 ext_in_valid  input  1  ext_in_data is valid.
REQ-016 ext_in_ready  output  1  bridge accepts ext_in_data this cycle.
REQ-017 ovf  output  1  sticky flag: a processor write was dropped.
REQ-018 udf  output  1  sticky flag: a processor read hit an empty FIFO.

Function
REQ-019 Outbound push SHALL occur on a rising edge where cpu_out_we=1 and the FIFO is not full, or is full but pops in the same cycle.
REQ-020 Outbound pop SHALL occur on a rising edge where ext_out_valid=1 and ext_out_ready=1.
REQ-021 ext_out_valid SHALL equal outbound non-empty; ext_out_data SHALL equal the head entry; both registered, no combinational path from any input.
REQ-022 Latency: a word pushed at edge N SHALL be visible on ext_out_data with ext_out_valid=1 in the cycle after edge N when the FIFO was empty.
REQ-023 cpu_out_we while full with no simultaneous pop SHALL drop the word, leave the FIFO unchanged and set ovf at that edge.
REQ-024 Inbound push SHALL occur when ext_in_valid=1 and ext_in_ready=1; ext_in_ready SHALL equal not-full and SHALL NOT depend on cpu_in_re.
REQ-025 cpu_in SHALL show the inbound head when non-empty and zero when empty; cpu_in_avail SHALL equal non-empty.
REQ-026 cpu_in_re while non-empty SHALL pop the head at that edge; the next entry, or zero, SHALL appear the following cycle.
REQ-027 cpu_in_re while empty SHALL leave state unchanged and set udf.
REQ-028 Simultaneous push and pop on a non-empty FIFO SHALL keep the count unchanged and preserve order.
REQ-029 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; full/empty SHALL come from a count of log2(DEPTH)+1 bits.
REQ-030 Ordering SHALL be strict FIFO in each direction; the two directions are independent.

Reset
REQ-031 With reset=0 at a rising edge, both FIFOs SHALL empty and ovf=udf=0.
REQ-032 During and after reset: ext_out_valid=0, ext_out_data=0, cpu_in=0, cpu_in_avail=0, cpu_out_full=0, ext_in_ready=1.
REQ-033 Reset SHALL take priority over simultaneous push or pop; words in flight SHALL be discarded.

Structure
REQ-034 A shared package SHALL hold the WIDTH and DEPTH defaults and the pointer-width constant.
REQ-035 A single sub-module io_fifo (synchronous FIFO with push, pop, full, empty, head) SHALL be instantiated twice, once per direction.

Verification
REQ-036 Reset, then cpu_out_we with 16'hA5A5 for one cycle, ext_out_ready=1 -> ext_out_valid=1 with 16'hA5A5 for exactly one cycle.
REQ-037 ext_out_ready=0, push 16'h0001..16'h0005 -> cpu_out_full=1 after the 4th push, 5th dropped and ovf=1; drain -> 0001..0004 in order.
REQ-038 ext_in pushes 16'h1111, 16'h2222 -> cpu_in=1111 and cpu_in_avail=1; cpu_in_re -> next cycle cpu_in=2222; cpu_in_re -> cpu_in=0, cpu_in_avail=0.
REQ-039 Empty inbound FIFO, cpu_in_re=1 -> udf=1, cpu_in stays 0.
REQ-040 Full outbound FIFO, cpu_out_we and ext_out_ready in the same cycle -> no ovf, count stays 4, order preserved.
REQ-041 Partially filled FIFOs, reset=0 for one edge -> all outputs at their REQ-032 values and the prior contents never appear.
